// File: rtl/mat_mult_engine.sv
// Purpose: pipelined N x N matrix multiplier, C = A*B, unsigned or two's-complement elements.
// Latency: K+1 edges from accepted start to done (K = N*N/LANES issue groups plus one drain cycle).
// Backpressure: none; start is ignored while busy and the result holds with done until the next start.
module mat_mult_engine #(
  parameter  int W     = 2,
  parameter  int N     = 4,
  parameter  int LANES = 2,
  localparam int OW    = 2 * W + $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                sgn,
  input  logic [N*N*W-1:0]    mat_A,
  input  logic [N*N*W-1:0]    mat_B,
  output logic                busy,
  output logic                done,
  output logic [N*N*OW-1:0]   mat_out
);

  localparam int K  = N * N / LANES;
  localparam int GW = (K > 1) ? $clog2(K) : 1;
  localparam int PW = 2 * W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              accept;

  // Operands captured at acceptance; later input changes cannot disturb a running operation.
  logic [N*N*W-1:0]  a_q, b_q;
  logic              sgn_q;

  // Issue counter and product pipeline stage (products plus the group they belong to).
  logic [GW-1:0]     g_q;
  logic [GW-1:0]     prod_g;
  logic              prod_vld;
  logic [PW-1:0]     prod_q [LANES][N];
  logic [PW-1:0]     prod_d [LANES][N];

  // Lane sums and the result matrix.
  logic [OW-1:0]     sum_d [LANES];
  logic [N*N*OW-1:0] mat_q;

  // Row/column of the group being issued and element index of the group being written.
  int                iss_row, iss_col, wr_base;

  assign iss_row = (int'(g_q) * LANES) / N;
  assign iss_col = (int'(g_q) * LANES) % N;
  assign wr_base = int'(prod_g) * LANES;
  assign mat_out = mat_q;

  // One W x W multiply; operands widened by one bit so unsigned and signed share a signed multiplier.
  function automatic logic [PW-1:0] mul_el(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic signed [W:0]    ax;
    logic signed [W:0]    bx;
    logic signed [PW+1:0] p;
    ax = signed'({s & a[W-1], a});
    bx = signed'({s & b[W-1], b});
    p  = ax * bx;
    return p[PW-1:0];
  endfunction

  // Widen a 2W-bit product to OW bits, sign- or zero-extending according to the mode.
  function automatic logic [OW-1:0] ext_prod(input logic [PW-1:0] p, input logic s);
    logic signed [PW:0] t;
    t = signed'({s & p[PW-1], p});
    return OW'(t);
  endfunction

  // State register; reset forces IDLE immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic, start acceptance and status outputs.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (g_q == GW'(K - 1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture on an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
    end else if (accept) begin
      a_q   <= mat_A;
      b_q   <= mat_B;
      sgn_q <= sgn;
    end
  end

  // N*LANES multipliers: every lane shares row A[r][*] and takes its own column of B.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      for (int k = 0; k < N; k++) begin
        prod_d[l][k] = mul_el(a_q[(N*N-1-(iss_row*N+k))*W +: W],
                              b_q[(N*N-1-(k*N+iss_col+l))*W +: W],
                              sgn_q);
      end
    end
  end

  // Issue counter and product register; a new start clears the pipeline so no stale group is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_q      <= '0;
      prod_g   <= '0;
      prod_vld <= 1'b0;
      for (int l = 0; l < LANES; l++)
        for (int k = 0; k < N; k++)
          prod_q[l][k] <= '0;
    end else if (accept) begin
      g_q      <= '0;
      prod_g   <= '0;
      prod_vld <= 1'b0;
      for (int l = 0; l < LANES; l++)
        for (int k = 0; k < N; k++)
          prod_q[l][k] <= '0;
    end else begin
      prod_vld <= (state_q == S_RUN);
      if (state_q == S_RUN) begin
        prod_q <= prod_d;
        prod_g <= g_q;
        g_q    <= (g_q == GW'(K - 1)) ? '0 : g_q + 1'b1;
      end
    end
  end

  // Adder tree: sum the N registered products of each lane in the operation's signedness.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      sum_d[l] = '0;
      for (int k = 0; k < N; k++)
        sum_d[l] = sum_d[l] + ext_prod(prod_q[l][k], sgn_q);
    end
  end

  // Result matrix: cleared on start, otherwise one group of LANES slots written per valid product set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mat_q <= '0;
    end else if (accept) begin
      mat_q <= '0;
    end else if (prod_vld) begin
      for (int l = 0; l < LANES; l++)
        mat_q[(N*N-1-(wr_base+l))*OW +: OW] <= sum_d[l];
    end
  end

endmodule

// File: tb/tb_mat_mult_engine.sv
module tb_mat_mult_engine;

  localparam int W   = 2;
  localparam int N   = 4;
  localparam int L   = 2;
  localparam int OW  = 6;
  localparam int K   = 8;
  localparam int W2  = 3;
  localparam int L2  = 4;
  localparam int OW2 = 8;
  localparam int K2  = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0, sgn = 1'b0;
  logic [N*N*W-1:0]    mat_A = '0, mat_B = '0;
  logic                busy, done;
  logic [N*N*OW-1:0]   mat_out;

  logic                start2 = 1'b0, sgn2 = 1'b0;
  logic [N*N*W2-1:0]   mat_A2 = '0, mat_B2 = '0;
  logic                busy2, done2;
  logic [N*N*OW2-1:0]  mat_out2;

  int n_app = 0;
  int n_bad = 0;

  mat_mult_engine #(.W(W), .N(N), .LANES(L)) dut (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn),
    .mat_A(mat_A), .mat_B(mat_B),
    .busy(busy), .done(done), .mat_out(mat_out)
  );

  mat_mult_engine #(.W(W2), .N(N), .LANES(L2)) dut4 (
    .clk(clk), .rst(rst), .start(start2), .sgn(sgn2),
    .mat_A(mat_A2), .mat_B(mat_B2),
    .busy(busy2), .done(done2), .mat_out(mat_out2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              sg;
    logic [N*N*W-1:0]  a;
    logic [N*N*W-1:0]  b;
    logic [N*N*OW-1:0] e;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_app++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [N*N*W-1:0] fill_in(input int v);
    logic [N*N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N*N; i++) r[(N*N-1-i)*W +: W] = W'(v);
    return r;
  endfunction

  function automatic logic [N*N*OW-1:0] fill_out(input int v);
    logic [N*N*OW-1:0] r;
    r = '0;
    for (int i = 0; i < N*N; i++) r[(N*N-1-i)*OW +: OW] = OW'(v);
    return r;
  endfunction

  function automatic logic [N*N*W-1:0] ident();
    logic [N*N*W-1:0] r;
    r = '0;
    for (int d = 0; d < N; d++) r[(N*N-1-(d*N+d))*W +: W] = W'(1);
    return r;
  endfunction

  function automatic logic [N*N*W-1:0] ramp_in();
    logic [N*N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N*N; i++) r[(N*N-1-i)*W +: W] = W'(i % 4);
    return r;
  endfunction

  // Ramp 0,1,2,3 repeated, read as unsigned (sx=0) or as 0,1,-2,-1 (sx=1), widened to OW.
  function automatic logic [N*N*OW-1:0] ramp_out(input bit sx);
    logic [N*N*OW-1:0] r;
    int v;
    r = '0;
    for (int i = 0; i < N*N; i++) begin
      v = i % 4;
      if (sx && v >= 2) v = v - 4;
      r[(N*N-1-i)*OW +: OW] = OW'(v);
    end
    return r;
  endfunction

  function automatic logic [N*N*W2-1:0] fill_in2(input int v);
    logic [N*N*W2-1:0] r;
    r = '0;
    for (int i = 0; i < N*N; i++) r[(N*N-1-i)*W2 +: W2] = W2'(v);
    return r;
  endfunction

  function automatic logic [N*N*OW2-1:0] fill_out2(input int v);
    logic [N*N*OW2-1:0] r;
    r = '0;
    for (int i = 0; i < N*N; i++) r[(N*N-1-i)*OW2 +: OW2] = OW2'(v);
    return r;
  endfunction

  // Drive operands at a falling edge, let the next rising edge (E0) accept, and check the accept edge.
  task automatic start_op(input logic sg, input logic [N*N*W-1:0] a, input logic [N*N*W-1:0] b);
    @(negedge clk);
    sgn   = sg;
    mat_A = a;
    mat_B = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_at_accept", busy, 1);
    chk("done_at_accept", done, 0);
    chk("cleared_at_accept", mat_out, 0);
  endtask

  // Count edges after E0 until done and cycles with busy high; optionally disturb inputs meanwhile.
  task automatic wait_done(input bit scramble, output int n, output int bc);
    n  = 0;
    bc = busy ? 1 : 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      #1;
      if (scramble) begin
        mat_A = $urandom;
        mat_B = $urandom;
        sgn   = 1'($urandom);
        start = (n == 2);
      end
      if (busy) bc++;
      if (done) break;
    end
    start = 1'b0;
  endtask

  task automatic run_vec(input int idx, input bit scramble);
    int n, bc;
    start_op(vt[idx].sg, vt[idx].a, vt[idx].b);
    wait_done(scramble, n, bc);
    chk($sformatf("latency[%0d]", idx), 128'(n), 128'(K + 1));
    chk($sformatf("busy_cycles[%0d]", idx), 128'(bc), 128'(K + 1));
    chk($sformatf("busy_low_at_done[%0d]", idx), busy, 0);
    chk($sformatf("result[%0d]", idx), mat_out, vt[idx].e);
  endtask

  task automatic run2(input logic sg, input int va, input int vb, input int ev);
    int n;
    @(negedge clk);
    sgn2   = sg;
    mat_A2 = fill_in2(va);
    mat_B2 = fill_in2(vb);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      #1;
      if (done2) break;
    end
    chk("l4_latency", 128'(n), 128'(K2 + 1));
    chk("l4_result", mat_out2, fill_out2(ev));
  endtask

  initial begin
    vt[0] = '{sg: 1'b0, a: ident(),    b: ramp_in(),  e: ramp_out(1'b0)};
    vt[1] = '{sg: 1'b0, a: fill_in(3), b: fill_in(3), e: fill_out(36)};
    vt[2] = '{sg: 1'b1, a: fill_in(2), b: fill_in(1), e: fill_out(-8)};
    vt[3] = '{sg: 1'b0, a: fill_in(2), b: fill_in(1), e: fill_out(8)};
    vt[4] = '{sg: 1'b1, a: fill_in(3), b: fill_in(3), e: fill_out(4)};
    vt[5] = '{sg: 1'b1, a: ident(),    b: ramp_in(),  e: ramp_out(1'b1)};
    vt[6] = '{sg: 1'b0, a: fill_in(1), b: ident(),    e: fill_out(1)};

    // Reset state, before any clock edge.
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mat_out", mat_out, 0);
    chk("rst_busy_l4", busy2, 0);
    chk("rst_done_l4", done2, 0);
    @(negedge clk);
    rst = 1'b0;

    // Table vectors, each started in the DONE cycle of the previous one.
    for (int i = 0; i < 7; i++) run_vec(i, 1'b0);

    // done and the result hold while no start arrives.
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("done_holds", done, 1);
      chk("result_holds", mat_out, vt[6].e);
    end

    // Inputs churn every cycle and a start is pulsed in RUN cycle 3.
    run_vec(1, 1'b1);

    // Asynchronous reset in RUN cycle 4, after two groups have been written.
    start_op(1'b0, fill_in(3), fill_in(3));
    repeat (3) @(posedge clk);
    #1;
    chk("partial_elem0", 128'(mat_out[N*N*OW-1 -: OW]), 128'(36));
    #2;
    rst = 1'b1;
    #1;
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_done", done, 0);
    chk("midrun_rst_mat_out", mat_out, 0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(2, 1'b0);

    // Four-lane, 3-bit instance.
    run2(1'b0, 7, 7, 196);
    run2(1'b1, 4, 3, -48);
    run2(1'b0, 4, 3, 48);

    $display("== %0d vectors applied, %0d miscompares ==", n_app, n_bad);
    $finish;
  end

endmodule
